// File: rtl/fp_exponent_normalizer_if.sv
// Purpose : bundles the start request, operands and results of the FP exponent normalizer.
// Latency : n/a (wiring only).
// Backpres: n/a; start is only honoured while the normalizer is idle.
// Ports   : master drives start/mant_in/exp_in; slave returns mant_out, shift_amount,
//           alu_op, adjust_enable, busy, done, zero_flag, underflow.
interface fp_exponent_normalizer_if #(
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 8
);
  logic                  start;
  logic [MANT_WIDTH:0]   mant_in;       // bit MANT_WIDTH = adder carry-out
  logic [EXP_WIDTH-1:0]  exp_in;
  logic [MANT_WIDTH-1:0] mant_out;
  logic [EXP_WIDTH-1:0]  shift_amount;
  logic [3:0]            alu_op;
  logic                  adjust_enable;
  logic                  busy;
  logic                  done;
  logic                  zero_flag;
  logic                  underflow;

  modport master (
    output start, mant_in, exp_in,
    input  mant_out, shift_amount, alu_op, adjust_enable, busy, done, zero_flag, underflow
  );

  modport slave (
    input  start, mant_in, exp_in,
    output mant_out, shift_amount, alu_op, adjust_enable, busy, done, zero_flag, underflow
  );
endinterface

// File: rtl/fp_exponent_normalizer.sv
// Purpose : iterative post-add normalizer; shifts the significand one bit per cycle until the
//           hidden bit sits at bit MANT_WIDTH-1 and reports the exponent adjustment needed.
// Latency : 2 cycles for no shift / carry right shift, k+3 cycles for k left shifts.
// Backpres: single op in flight; start is ignored (not queued) while busy.
// Ports   : clk, reset (async active-high), bus (slave modport): start/mant_in/exp_in in;
//           mant_out/shift_amount/alu_op/adjust_enable/busy/done/zero_flag/underflow out.
module fp_exponent_normalizer #(
  parameter int MANT_WIDTH = 24,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  fp_exponent_normalizer_if.slave bus
);

  localparam int MW = MANT_WIDTH + 1;
  localparam logic [3:0] OP_INC = 4'b0000;
  localparam logic [3:0] OP_DEC = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_SHIFT_L,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic [EXP_WIDTH-1:0]  exp_q, exp_d;
  logic [EXP_WIDTH-1:0]  count_q, count_d;
  logic [MANT_WIDTH-1:0] mant_out_q, mant_out_d;
  logic [EXP_WIDTH-1:0]  shamt_q, shamt_d;
  logic [3:0]            op_q, op_d;
  logic                  adj_q, adj_d;
  logic                  zero_q, zero_d;
  logic                  unf_q, unf_d;

  // One bit wider than the exponent so the floor comparison cannot wrap.
  logic [EXP_WIDTH:0]    count_inc;
  assign count_inc = {1'b0, count_q} + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mant_q     <= '0;
      exp_q      <= '0;
      count_q    <= '0;
      mant_out_q <= '0;
      shamt_q    <= '0;
      op_q       <= OP_INC;
      adj_q      <= 1'b0;
      zero_q     <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mant_q     <= mant_d;
      exp_q      <= exp_d;
      count_q    <= count_d;
      mant_out_q <= mant_out_d;
      shamt_q    <= shamt_d;
      op_q       <= op_d;
      adj_q      <= adj_d;
      zero_q     <= zero_d;
      unf_q      <= unf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mant_d     = mant_q;
    exp_d      = exp_q;
    count_d    = count_q;
    mant_out_d = mant_out_q;
    shamt_d    = shamt_q;
    op_d       = op_q;
    adj_d      = adj_q;
    zero_d     = zero_q;
    unf_d      = unf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mant_d  = bus.mant_in;
          exp_d   = bus.exp_in;
          count_d = '0;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        if (mant_q == '0) begin
          zero_d  = 1'b1;
          count_d = '0;
          op_d    = OP_INC;
          state_d = S_DONE;
        end else if (mant_q[MW-1]) begin
          // Carry out of the adder: one right shift, LSB is dropped.
          mant_d  = mant_q >> 1;
          count_d = EXP_WIDTH'(1);
          op_d    = OP_INC;
          state_d = S_DONE;
        end else if (mant_q[MW-2]) begin
          count_d = '0;
          op_d    = OP_INC;
          state_d = S_DONE;
        end else begin
          op_d    = OP_DEC;
          state_d = S_SHIFT_L;
        end
      end

      S_SHIFT_L: begin
        if (mant_q[MW-2]) begin
          state_d = S_DONE;
        end else if (count_inc >= {1'b0, exp_q}) begin
          // Another shift would take the exponent below 1.
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          mant_d  = mant_q << 1;
          count_d = count_inc[EXP_WIDTH-1:0];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results are captured on entry to DONE so they are already valid while done is high.
    if (state_d == S_DONE) begin
      mant_out_d = mant_d[MANT_WIDTH-1:0];
      shamt_d    = count_d;
      adj_d      = (count_d != '0);
    end
  end

  assign bus.mant_out      = mant_out_q;
  assign bus.shift_amount  = shamt_q;
  assign bus.alu_op        = op_q;
  assign bus.adjust_enable = adj_q;
  assign bus.zero_flag     = zero_q;
  assign bus.underflow     = unf_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);

endmodule

// File: tb/tb_fp_exponent_normalizer.sv
module tb_fp_exponent_normalizer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_exponent_normalizer_if bus ();

  fp_exponent_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [24:0] mant;
    logic [7:0]  exp;
    logic [23:0] e_mant;
    logic [7:0]  e_shamt;
    logic [3:0]  e_op;
    logic        e_adj;
    logic        e_zero;
    logic        e_unf;
    int          e_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [24:0] m, input logic [7:0] e, input logic [23:0] em,
                              input logic [7:0] es, input logic [3:0] eo, input logic ea,
                              input logic ez, input logic eu, input int el);
    vec_t v;
    v.mant = m; v.exp = e; v.e_mant = em; v.e_shamt = es; v.e_op = eo;
    v.e_adj = ea; v.e_zero = ez; v.e_unf = eu; v.e_lat = el;
    return v;
  endfunction

  // Reference: find the leading one, the number of left shifts it needs, and clamp by the
  // exponent floor (exponent may not go below 1).
  function automatic vec_t model(input logic [24:0] m, input logic [7:0] e);
    vec_t        v;
    logic [24:0] tmp;
    int          p, k, lim, sh;
    v.mant = m; v.exp = e;
    v.e_zero = 1'b0; v.e_unf = 1'b0;
    if (m == 0) begin
      v.e_mant = 24'h0; v.e_shamt = 8'd0; v.e_op = 4'b0000; v.e_zero = 1'b1; v.e_lat = 2;
    end else if (m[24]) begin
      tmp = m >> 1;
      v.e_mant = tmp[23:0]; v.e_shamt = 8'd1; v.e_op = 4'b0000; v.e_lat = 2;
    end else if (m[23]) begin
      v.e_mant = m[23:0]; v.e_shamt = 8'd0; v.e_op = 4'b0000; v.e_lat = 2;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      k   = 23 - p;
      lim = (e == 0) ? 0 : int'(e) - 1;
      sh  = (k < lim) ? k : lim;
      tmp = m << sh;
      v.e_mant  = tmp[23:0];
      v.e_shamt = 8'(sh);
      v.e_op    = 4'b0011;
      v.e_unf   = (k > lim);
      v.e_lat   = sh + 3;
    end
    v.e_adj = (v.e_shamt != 0);
    return v;
  endfunction

  task automatic run_op(input string tag, input vec_t v);
    int          cyc;
    logic [23:0] held;
    bus.mant_in = v.mant;
    bus.exp_in  = v.exp;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    chk({tag, ":busy1"}, bus.busy, 1'b1);
    while (bus.done !== 1'b1 && cyc < 64) begin
      step();
      cyc++;
    end
    chk({tag, ":latency"}, cyc, v.e_lat);
    chk({tag, ":mant_out"}, bus.mant_out, v.e_mant);
    chk({tag, ":shift_amount"}, bus.shift_amount, v.e_shamt);
    chk({tag, ":alu_op"}, bus.alu_op, v.e_op);
    chk({tag, ":adjust_enable"}, bus.adjust_enable, v.e_adj);
    chk({tag, ":zero_flag"}, bus.zero_flag, v.e_zero);
    chk({tag, ":underflow"}, bus.underflow, v.e_unf);
    held = bus.mant_out;
    step();
    chk({tag, ":done_drop"}, bus.done, 1'b0);
    chk({tag, ":busy_idle"}, bus.busy, 1'b0);
    chk({tag, ":hold"}, bus.mant_out, held);
  endtask

  vec_t tbl[11];

  initial begin
    int          cyc;
    int          ndone;
    logic [24:0] m;
    logic [7:0]  e;

    tbl[0]  = mk(25'h1800000, 8'h80, 24'hC00000, 8'd1,  4'b0000, 1'b1, 1'b0, 1'b0, 2);
    tbl[1]  = mk(25'h0800000, 8'h80, 24'h800000, 8'd0,  4'b0000, 1'b0, 1'b0, 1'b0, 2);
    tbl[2]  = mk(25'h0000100, 8'h80, 24'h800000, 8'd15, 4'b0011, 1'b1, 1'b0, 1'b0, 18);
    tbl[3]  = mk(25'h0000001, 8'h05, 24'h000010, 8'd4,  4'b0011, 1'b1, 1'b0, 1'b1, 7);
    tbl[4]  = mk(25'h0000000, 8'h80, 24'h000000, 8'd0,  4'b0000, 1'b0, 1'b1, 1'b0, 2);
    tbl[5]  = mk(25'h0000040, 8'h01, 24'h000040, 8'd0,  4'b0011, 1'b0, 1'b0, 1'b1, 3);
    tbl[6]  = mk(25'h0000001, 8'h80, 24'h800000, 8'd23, 4'b0011, 1'b1, 1'b0, 1'b0, 26);
    tbl[7]  = mk(25'h1FFFFFF, 8'h80, 24'hFFFFFF, 8'd1,  4'b0000, 1'b1, 1'b0, 1'b0, 2);
    tbl[8]  = mk(25'h0400000, 8'h00, 24'h400000, 8'd0,  4'b0011, 1'b0, 1'b0, 1'b1, 3);
    tbl[9]  = mk(25'h0400000, 8'h02, 24'h800000, 8'd1,  4'b0011, 1'b1, 1'b0, 1'b0, 4);
    tbl[10] = mk(25'h0000003, 8'hFF, 24'hC00000, 8'd22, 4'b0011, 1'b1, 1'b0, 1'b0, 25);

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mant_in = '0;
    bus.exp_in  = '0;
    #2;
    chk("rst:mant_out", bus.mant_out, 24'h0);
    chk("rst:shift_amount", bus.shift_amount, 8'h0);
    chk("rst:alu_op", bus.alu_op, 4'h0);
    chk("rst:adjust_enable", bus.adjust_enable, 1'b0);
    chk("rst:busy", bus.busy, 1'b0);
    chk("rst:done", bus.done, 1'b0);
    chk("rst:zero_flag", bus.zero_flag, 1'b0);
    chk("rst:underflow", bus.underflow, 1'b0);
    repeat (2) step();
    reset = 1'b0;
    step();

    // Directed table, applied back to back.
    for (int i = 0; i < 11; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // start while busy must be dropped, not queued.
    bus.mant_in = 25'h0000001;
    bus.exp_in  = 8'h80;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    repeat (3) begin step(); cyc++; end
    bus.mant_in = 25'h1800000;
    bus.start   = 1'b1;
    step();
    cyc++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 64) begin step(); cyc++; end
    chk("busy_start:latency", cyc, 26);
    chk("busy_start:shift_amount", bus.shift_amount, 8'd23);
    chk("busy_start:mant_out", bus.mant_out, 24'h800000);
    ndone = 0;
    repeat (10) begin step(); if (bus.done) ndone++; end
    chk("busy_start:extra_done", ndone, 0);

    // Reset in the middle of a long left-shift run.
    bus.mant_in = 25'h0000001;
    bus.exp_in  = 8'h80;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    chk("midrst:mant_out", bus.mant_out, 24'h0);
    chk("midrst:shift_amount", bus.shift_amount, 8'h0);
    chk("midrst:alu_op", bus.alu_op, 4'h0);
    chk("midrst:adjust_enable", bus.adjust_enable, 1'b0);
    chk("midrst:busy", bus.busy, 1'b0);
    chk("midrst:done", bus.done, 1'b0);
    step();
    reset = 1'b0;
    ndone = 0;
    repeat (30) begin step(); if (bus.done) ndone++; end
    chk("midrst:no_done", ndone, 0);
    run_op("after_rst", tbl[2]);

    // Randomized operands against the reference model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       m = 25'h0;
        1:       m = 25'h1000000 | 25'($urandom);
        default: m = 25'($urandom) >> $urandom_range(1, 24);
      endcase
      if ($urandom_range(0, 1) == 0) e = 8'($urandom_range(0, 30));
      else                           e = 8'($urandom);
      run_op($sformatf("rnd%0d", n), model(m, e));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
